// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: fixed or rotating priority, host bus handshake,
// and per-tenure beat limiting. Registered hreq/dack/end_pulse outputs.
module dma_priority_arbiter #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dreq,
    input  logic [3:0] mask,
    input  logic       rotate_en,
    input  logic       hack,
    input  logic       xfer_done,
    input  logic       eop_in,
    output logic       hreq,
    output logic [3:0] dack,
    output logic [1:0] grant_ch,
    output logic       busy,
    output logic       end_pulse
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGrant,
        StRelease
    } state_e;

    localparam logic [7:0] LastBeat = 8'(MAX_BEATS - 1);

    state_e     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] prio_ptr_q, prio_ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       hreq_q, hreq_d;
    logic [3:0] dack_q, dack_d;
    logic       end_pulse_q, end_pulse_d;

    logic [3:0] eff;
    logic [7:0] eff_dbl;
    logic [3:0] eff_rot;
    logic [1:0] fixed_win;
    logic [1:0] rot_win;
    logic [1:0] arb_win;
    logic       last_beat;
    logic       grant_exit;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign eff = dreq & ~mask;

    // Rotating search: shift eff so prio_ptr lands at bit 0, then add the offset back.
    always_comb begin
        eff_dbl   = {eff, eff} >> prio_ptr_q;
        eff_rot   = eff_dbl[3:0];
        fixed_win = lowest_idx(eff);
        rot_win   = prio_ptr_q + lowest_idx(eff_rot);
        arb_win   = rotate_en ? rot_win : fixed_win;
    end

    assign last_beat = xfer_done && (beat_cnt_q == LastBeat);

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        prio_ptr_d = prio_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_exit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (eff != 4'b0000) state_d = StReq;
            end
            StReq: begin
                if (eff == 4'b0000) begin
                    state_d = StIdle;
                end else if (hack) begin
                    state_d    = StGrant;
                    winner_d   = arb_win;
                    beat_cnt_d = 8'd0;
                end
            end
            StGrant: begin
                // Losing the bus outranks every other way a tenure can end.
                if (!hack) begin
                    state_d    = StIdle;
                    grant_exit = 1'b1;
                end else if (eop_in || last_beat || !eff[winner_q]) begin
                    state_d    = StRelease;
                    grant_exit = 1'b1;
                end else if (xfer_done) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (grant_exit && rotate_en) prio_ptr_d = winner_q + 2'd1;
            end
            StRelease: begin
                if (!hack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hreq_d      = (state_d == StReq) || (state_d == StGrant);
        dack_d      = (state_d == StGrant) ? (4'b0001 << winner_d) : 4'b0000;
        end_pulse_d = grant_exit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            winner_q    <= 2'd0;
            prio_ptr_q  <= 2'd0;
            beat_cnt_q  <= 8'd0;
            hreq_q      <= 1'b0;
            dack_q      <= 4'b0000;
            end_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            prio_ptr_q  <= prio_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            hreq_q      <= hreq_d;
            dack_q      <= dack_d;
            end_pulse_q <= end_pulse_d;
        end
    end

    assign hreq      = hreq_q;
    assign dack      = dack_q;
    assign grant_ch  = winner_q;
    assign busy      = (state_q != StIdle);
    assign end_pulse = end_pulse_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios then random traffic, every cycle
// compared against a tenure-level reference model.
module tb_dma_priority_arbiter;

    localparam int Beats = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dreq;
    logic [3:0] mask;
    logic       rotate_en;
    logic       hack;
    logic       xfer_done;
    logic       eop_in;
    logic       hreq;
    logic [3:0] dack;
    logic [1:0] grant_ch;
    logic       busy;
    logic       end_pulse;

    int n_asserts = 0;
    int n_fail    = 0;

    dma_priority_arbiter #(
        .MAX_BEATS(Beats)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dreq     (dreq),
        .mask     (mask),
        .rotate_en(rotate_en),
        .hack     (hack),
        .xfer_done(xfer_done),
        .eop_in   (eop_in),
        .hreq     (hreq),
        .dack     (dack),
        .grant_ch (grant_ch),
        .busy     (busy),
        .end_pulse(end_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: which phase of a tenure the bus is in, who owns it, beats used.
    localparam int PIdle = 0, PAsk = 1, POwn = 2, PDrop = 3;
    int m_phase = PIdle;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_used  = 0;
    bit m_ended = 0;
    bit m_rst   = 0;

    function automatic int pick(input logic [3:0] e, input int ptr, input bit rot);
        int start;
        start = rot ? ptr : 0;
        for (int k = 0; k < 4; k++) begin
            if (e[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0] e;
        e       = dreq & ~mask;
        m_ended = 0;
        m_rst   = reset;
        if (reset) begin
            m_phase = PIdle;
            m_owner = 0;
            m_ptr   = 0;
            m_used  = 0;
            return;
        end
        case (m_phase)
            PIdle: if (e != 0) m_phase = PAsk;
            PAsk: begin
                if (e == 0) m_phase = PIdle;
                else if (hack) begin
                    m_owner = pick(e, m_ptr, rotate_en);
                    m_used  = 0;
                    m_phase = POwn;
                end
            end
            POwn: begin
                if (!hack) begin
                    m_phase = PIdle;
                    m_ended = 1;
                end else if (eop_in || (xfer_done && m_used + 1 == Beats) || !e[m_owner]) begin
                    m_phase = PDrop;
                    m_ended = 1;
                end else if (xfer_done) begin
                    m_used++;
                end
                if (m_ended && rotate_en) m_ptr = (m_owner + 1) % 4;
            end
            default: if (!hack) m_phase = PIdle;
        endcase
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".hreq"}, int'(hreq), int'(m_phase == PAsk || m_phase == POwn));
        chk({tag, ".dack"}, int'(dack), (m_phase == POwn) ? (1 << m_owner) : 0);
        chk({tag, ".busy"}, int'(busy), int'(m_phase != PIdle));
        chk({tag, ".end_pulse"}, int'(end_pulse), int'(m_ended));
        if (m_phase == POwn || m_rst) chk({tag, ".grant_ch"}, int'(grant_ch), m_owner);
    endtask

    int ep;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1; dreq = 0; mask = 0; rotate_en = 0; hack = 0; xfer_done = 0; eop_in = 0;
        #1;
        tick("reset0");
        tick("reset1");

        // Fixed priority: ch1 beats ch2.
        reset = 0; dreq = 4'b0110;
        tick("fix_req");
        tick("fix_wait");
        hack = 1;
        tick("fix_grant");
        chk("fix_dack", int'(dack), 2);
        chk("fix_ch", int'(grant_ch), 1);
        dreq = 4'b0000;
        tick("fix_withdraw");
        hack = 0;
        tick("fix_idle");

        // Rotating priority through all four channels.
        rotate_en = 1; dreq = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            hack = 1;
            tick("rot_req");
            tick("rot_grant");
            chk("rot_order", int'(grant_ch), order[t]);
            eop_in = 1;
            tick("rot_eop");
            eop_in = 0; hack = 0;
            tick("rot_idle");
        end

        // Beat limit on ch2.
        rotate_en = 0; dreq = 4'b0100; hack = 1;
        tick("beat_req");
        tick("beat_grant");
        ep = 0;
        for (int b = 0; b < Beats; b++) begin
            xfer_done = 1;
            tick("beat_x");
            ep += int'(end_pulse);
            xfer_done = 0;
            tick("beat_gap");
            ep += int'(end_pulse);
        end
        chk("beat_end_cnt", ep, 1);
        chk("beat_hreq", int'(hreq), 0);
        hack = 0;
        tick("beat_idle");

        // eop_in together with the last beat gives one exit.
        hack = 1;
        tick("both_req");
        tick("both_grant");
        for (int b = 0; b < Beats - 1; b++) begin
            xfer_done = 1;
            tick("both_x");
        end
        xfer_done = 1; eop_in = 1;
        tick("both_last");
        xfer_done = 0; eop_in = 0;
        tick("both_after");
        hack = 0;
        tick("both_idle");

        // eop_in during beat 2.
        hack = 1;
        tick("eop_req");
        tick("eop_grant");
        xfer_done = 1;
        tick("eop_beat1");
        xfer_done = 0; eop_in = 1;
        tick("eop_hit");
        chk("eop_dack", int'(dack), 0);
        eop_in = 0; hack = 0; dreq = 0;
        tick("eop_idle");

        // Masked request never raises hreq.
        mask = 4'b0001; dreq = 4'b0001;
        for (int i = 0; i < 3; i++) tick("mask");
        chk("mask_hreq", int'(hreq), 0);
        mask = 0; dreq = 0;
        tick("mask_clr");

        // Host revoke mid-grant, then reset mid-grant.
        dreq = 4'b1000; hack = 1;
        tick("rev_req");
        tick("rev_grant");
        hack = 0;
        tick("rev_drop");
        chk("rev_dack", int'(dack), 0);
        hack = 1;
        tick("rst_req");
        tick("rst_grant");
        reset = 1;
        tick("rst_mid");
        chk("rst_endp", int'(end_pulse), 0);
        reset = 0; dreq = 0; hack = 0;
        tick("rst_idle");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            dreq      = 4'($urandom);
            mask      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            hack      = ($urandom_range(0, 9) < 8);
            xfer_done = ($urandom_range(0, 9) < 4);
            eop_in    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) rotate_en = ~rotate_en;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 16, max xfer_done beats per bus tenure (range 1..256).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 dreq  in  4  per-channel DMA request, level-sensitive; bit n = channel n.
REQ-005 mask  in  4  per-channel disable; 1 = channel ignored.
REQ-006 rotate_en  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
REQ-007 hack  in  1  host bus acknowledge.
REQ-008 xfer_done  in  1  one-cycle pulse from datapath, one transfer beat completed.
REQ-009 eop_in  in  1  external end-of-process; terminates current service.
REQ-010 hreq  out  1  host bus request, registered.
REQ-011 dack  out  4  one-hot channel acknowledge, registered; all-zero when no grant.
REQ-012 grant_ch  out  2  index of granted channel; valid while dack != 0.
REQ-013 busy  out  1  1 whenever state != IDLE.
REQ-014 end_pulse  out  1  one-cycle pulse when a grant ends (any cause).

Function
REQ-015 Effective request eff = dreq & ~mask, evaluated combinationally each cycle.
REQ-016 The FSM SHALL have states IDLE, REQ, GRANT, RELEASE.
REQ-017 IDLE: eff != 0 -> REQ, hreq = 1 from next cycle; else stay, hreq = 0.
REQ-018 REQ: eff == 0 -> IDLE, hreq = 0 next cycle (request withdrawn, no grant).
REQ-019 REQ: hack = 1 and eff != 0 -> winner latched from eff that cycle, GRANT; dack/grant_ch valid next cycle.
REQ-020 Fixed priority: lowest-index set bit of eff wins.
REQ-021 Rotating priority: search starts at prio_ptr, ascending mod 4; first set bit wins.
REQ-022 prio_ptr SHALL update to (winner+1) mod 4 on every GRANT exit when rotate_en = 1; unchanged when rotate_en = 0.
REQ-023 Winner is fixed for the whole tenure; new requests never preempt a grant.
REQ-024 GRANT: beat_cnt (8-bit) clears on entry, increments on each xfer_done.
REQ-025 GRANT exit to RELEASE, priority order: eop_in = 1; xfer_done with beat_cnt == MAX_BEATS-1; eff[winner] == 0.
REQ-026 GRANT: hack = 0 (host revokes bus) -> IDLE directly, hreq = 0 and dack = 0 next cycle.
REQ-027 end_pulse SHALL assert exactly one cycle on every GRANT exit, including host revoke.
REQ-028 RELEASE: dack = 0, hreq = 0; stay until hack == 0, then IDLE.
REQ-029 xfer_done outside GRANT SHALL be ignored.
REQ-030 eop_in and xfer_done together at the last beat: single exit, single end_pulse.
REQ-031 Changing mask/rotate_en mid-grant SHALL affect only REQ-025 eff term and the next arbitration.
REQ-032 dack SHALL never have more than one bit set; dack != 0 only in GRANT.

Reset
REQ-033 On reset = 1 at a clock edge: state IDLE, hreq 0, dack 0, grant_ch 0, busy 0, end_pulse 0, prio_ptr 0, beat_cnt 0.
REQ-034 Reset mid-GRANT SHALL drop hreq and dack on the next edge, no end_pulse.
REQ-035 Reset has priority over all other inputs.

Verification
REQ-036 Fixed: rotate_en=0, dreq=4'b0110, hack after 2 cycles -> dack=4'b0010, grant_ch=1.
REQ-037 Rotating: dreq=4'b1111 held, rotate_en=1, hack toggled per tenure -> grants in order ch0, ch1, ch2, ch3, ch0.
REQ-038 Beat limit: MAX_BEATS=4, dreq[2] held, 4 xfer_done pulses -> RELEASE after 4th, end_pulse once, hreq 0.
REQ-039 EOP/mask: eop_in during beat 2 -> RELEASE next cycle; mask[0]=1 with dreq=4'b0001 -> hreq stays 0.
REQ-040 Abort/reset: hack dropped mid-GRANT -> IDLE, dack 0 next cycle; reset mid-GRANT -> all outputs 0, no end_pulse.
